// File: rtl/striper_nlane_if.sv
// Source-to-striper bundle: word stream and controls in, lane group and status out.
// No ready signal; the striper accepts a word on every cycle valid_in is high.
interface striper_nlane_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int PTR_W      = 3
);
    logic [DATA_WIDTH-1:0]           data_in;
    logic                            valid_in;
    logic                            mode_align;
    logic                            flush;
    logic [NUM_LANES*DATA_WIDTH-1:0] lanes_out;
    logic [NUM_LANES-1:0]            valid_out;
    logic [PTR_W-1:0]                lane_ptr;
    logic                            group_done;

    modport master (
        output data_in, valid_in, mode_align, flush,
        input  lanes_out, valid_out, lane_ptr, group_done
    );

    modport slave (
        input  data_in, valid_in, mode_align, flush,
        output lanes_out, valid_out, lane_ptr, group_done
    );
endinterface

// File: rtl/striper_nlane.sv
// Round-robin word striper over NUM_LANES lanes (STRIPE or ALIGN), registered outputs, latency 1.
// No backpressure: every word presented with valid_in is accepted in that cycle.
module striper_nlane #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int PTR_W      = 3
) (
    input  logic            clk_2f,
    input  logic            reset,
    striper_nlane_if.slave  bus
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d, mode_eff;
    logic [PTR_W-1:0]      ptr_q, ptr_d, k;
    logic                  last;
    logic [DATA_WIDTH-1:0] stage_q [NUM_LANES];
    logic [DATA_WIDTH-1:0] stage_d [NUM_LANES];
    logic [DATA_WIDTH-1:0] lane_q  [NUM_LANES];
    logic [DATA_WIDTH-1:0] lane_d  [NUM_LANES];
    logic [NUM_LANES-1:0]  vld_q, vld_d;
    logic                  gd_q, gd_d;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        ptr_d    = ptr_q;
        stage_d  = stage_q;
        lane_d   = lane_q;
        vld_d    = '0;
        gd_d     = 1'b0;
        // A word arriving in IDLE already follows the mode being latched with it
        mode_eff = (state_q == IDLE) ? bus.mode_align : mode_q;
        last     = (ptr_q == PTR_W'(NUM_LANES - 1));
        k        = ptr_q + PTR_W'(bus.valid_in);

        if (state_q == IDLE)
            mode_d = bus.mode_align;

        if (bus.valid_in) begin
            if (last) begin
                ptr_d   = '0;
                state_d = IDLE;
            end else begin
                ptr_d   = ptr_q + PTR_W'(1);
                state_d = FILL;
            end
        end
        if (bus.flush) begin
            ptr_d   = '0;
            state_d = IDLE;
        end

        if (!mode_eff) begin
            if (bus.valid_in) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (PTR_W'(i) == ptr_q) begin
                        lane_d[i] = bus.data_in;
                        vld_d[i]  = 1'b1;
                    end
                end
            end
        end else begin
            if (bus.valid_in) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (PTR_W'(i) == ptr_q)
                        stage_d[i] = bus.data_in;
                end
            end
            if (bus.valid_in && last) begin
                lane_d = stage_d;
                vld_d  = '1;
                gd_d   = 1'b1;
            end else if (bus.flush && k != '0) begin
                // Partial release: k held words on the low lanes, upper lanes zeroed
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (PTR_W'(i) < k) begin
                        lane_d[i] = stage_d[i];
                        vld_d[i]  = 1'b1;
                    end else begin
                        lane_d[i] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            ptr_q   <= '0;
            stage_q <= '{default: '0};
            lane_q  <= '{default: '0};
            vld_q   <= '0;
            gd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ptr_q   <= ptr_d;
            stage_q <= stage_d;
            lane_q  <= lane_d;
            vld_q   <= vld_d;
            gd_q    <= gd_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
        assign bus.lanes_out[g*DATA_WIDTH +: DATA_WIDTH] = lane_q[g];
    end

    assign bus.valid_out  = vld_q;
    assign bus.lane_ptr   = ptr_q;
    assign bus.group_done = gd_q;
endmodule

// File: tb/tb_striper_nlane.sv
// Drives one stimulus stream into 2-, 3- and 4-lane striper instances and checks each
// cycle against a queue-based group model, plus hand-computed literal expectations.
module tb_striper_nlane;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in, mode_align, flush;
    logic        armed = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gl
        localparam int NL = g + 2;

        striper_nlane_if #(.DATA_WIDTH(32), .NUM_LANES(NL), .PTR_W(3)) u_if ();

        assign u_if.data_in    = data_in;
        assign u_if.valid_in   = valid_in;
        assign u_if.mode_align = mode_align;
        assign u_if.flush      = flush;

        striper_nlane #(.DATA_WIDTH(32), .NUM_LANES(NL), .PTR_W(3)) u_dut (
            .clk_2f (clk),
            .reset  (reset),
            .bus    (u_if.slave)
        );

        logic [31:0]      grp [$];
        logic             m_mode;
        logic             align;
        logic [31:0]      e_lane [NL];
        logic [NL-1:0]    e_vld;
        logic             e_gd;
        int               e_ptr;
        int               pos;
        logic [NL*32-1:0] e_pack;

        // Model: the current group is a queue of accepted words; its size is the lane pointer
        always @(posedge clk) begin
            if (reset) begin
                grp.delete();
                m_mode = 1'b0;
                e_vld  = '0;
                e_gd   = 1'b0;
                for (int i = 0; i < NL; i++) e_lane[i] = '0;
            end else begin
                e_vld = '0;
                e_gd  = 1'b0;
                align = (grp.size() == 0) ? mode_align : m_mode;
                if (grp.size() == 0) m_mode = mode_align;
                if (valid_in) begin
                    pos = grp.size();
                    grp.push_back(data_in);
                    if (!align) begin
                        e_lane[pos] = data_in;
                        e_vld[pos]  = 1'b1;
                    end
                    if (grp.size() == NL) begin
                        if (align) begin
                            for (int i = 0; i < NL; i++) e_lane[i] = grp[i];
                            e_vld = '1;
                            e_gd  = 1'b1;
                        end
                        grp.delete();
                    end
                end
                if (flush) begin
                    if (align && grp.size() > 0) begin
                        for (int i = 0; i < NL; i++) begin
                            if (i < grp.size()) begin
                                e_lane[i] = grp[i];
                                e_vld[i]  = 1'b1;
                            end else begin
                                e_lane[i] = '0;
                            end
                        end
                    end
                    grp.delete();
                end
            end
            e_ptr = grp.size();
        end

        always @(negedge clk) begin
            if (armed) begin
                for (int i = 0; i < NL; i++) e_pack[i*32 +: 32] = e_lane[i];
                chk($sformatf("model lanes_out nl%0d", NL), 128'(u_if.lanes_out), 128'(e_pack));
                chk($sformatf("model valid_out nl%0d", NL), 128'(u_if.valid_out), 128'(e_vld));
                chk($sformatf("model lane_ptr nl%0d", NL), 128'(u_if.lane_ptr), 128'(e_ptr));
                chk($sformatf("model group_done nl%0d", NL), 128'(u_if.group_done), 128'(e_gd));
            end
        end
    end

    // Inputs change 2 time units after a posedge; after step() the outputs of that edge are visible
    task automatic step(input logic v, input logic [31:0] d, input logic f);
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = '0; flush = 1'b0; mode_align = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        armed = 1'b1;

        // Reset state
        chk("reset valid nl4", 128'(gl[2].u_if.valid_out), 128'h0);
        chk("reset lanes nl4", 128'(gl[2].u_if.lanes_out), 128'h0);
        chk("reset ptr nl4", 128'(gl[2].u_if.lane_ptr), 128'h0);
        chk("reset done nl4", 128'(gl[2].u_if.group_done), 128'h0);

        // STRIPE, two lanes
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        chk("t1 w0 valid", 128'(gl[0].u_if.valid_out), 128'h1);
        chk("t1 w0 lane0", 128'(gl[0].u_if.lanes_out[31:0]), 128'hFFFFFFFF);
        step(1'b1, 32'hEEEEEEEE, 1'b0);
        chk("t1 w1 valid", 128'(gl[0].u_if.valid_out), 128'h2);
        chk("t1 w1 lane1", 128'(gl[0].u_if.lanes_out[63:32]), 128'hEEEEEEEE);
        step(1'b1, 32'hDDDDDDDD, 1'b0);
        chk("t1 w2 valid", 128'(gl[0].u_if.valid_out), 128'h1);
        step(1'b1, 32'hCCCCCCCC, 1'b0);
        chk("t1 w3 valid", 128'(gl[0].u_if.valid_out), 128'h2);
        chk("t1 w3 lanes", 128'(gl[0].u_if.lanes_out), 128'hCCCCCCCC_DDDDDDDD);

        // STRIPE with a 3-cycle gap: pointer holds, valid drops
        step(1'b1, 32'h12345678, 1'b0);
        chk("t4 w0 ptr", 128'(gl[0].u_if.lane_ptr), 128'h1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("t4 gap valid", 128'(gl[0].u_if.valid_out), 128'h0);
            chk("t4 gap ptr", 128'(gl[0].u_if.lane_ptr), 128'h1);
        end
        step(1'b1, 32'h9ABCDEF0, 1'b0);
        chk("t4 w1 valid", 128'(gl[0].u_if.valid_out), 128'h2);
        chk("t4 w1 lanes", 128'(gl[0].u_if.lanes_out), 128'h9ABCDEF0_12345678);

        // STRIPE flush realigns the pointer
        step(1'b1, 32'h55555555, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("stripe flush ptr nl3", 128'(gl[1].u_if.lane_ptr), 128'h0);
        chk("stripe flush valid nl3", 128'(gl[1].u_if.valid_out), 128'h0);
        step(1'b0, 32'h0, 1'b1);

        // Three-lane wrap
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h60000000 + 32'(i), 1'b0);
            chk("t6 valid", 128'(gl[1].u_if.valid_out), 128'(1 << (i % 3)));
            chk("t6 ptr", 128'(gl[1].u_if.lane_ptr), 128'((i + 1) % 3));
        end

        // ALIGN, four lanes, then back-to-back groups
        mode_align = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h11111111 * 32'(i + 1), 1'b0);
            if (i < 3) chk("t2 fill valid", 128'(gl[2].u_if.valid_out), 128'h0);
        end
        chk("t2 valid", 128'(gl[2].u_if.valid_out), 128'hF);
        chk("t2 lanes", 128'(gl[2].u_if.lanes_out), 128'h44444444_33333333_22222222_11111111);
        chk("t2 done", 128'(gl[2].u_if.group_done), 128'h1);
        step(1'b0, 32'h0, 1'b0);
        chk("t2 after valid", 128'(gl[2].u_if.valid_out), 128'h0);
        chk("t2 after done", 128'(gl[2].u_if.group_done), 128'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hB0000000 + 32'(i), 1'b0);
            chk("b2b done nl4", 128'(gl[2].u_if.group_done), 128'((i % 4) == 3));
        end

        // ALIGN, three lanes, partial flush
        do_reset();
        step(1'b1, 32'hAAAAAAAA, 1'b0);
        step(1'b1, 32'hBBBBBBBB, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        chk("t3 valid", 128'(gl[1].u_if.valid_out), 128'h3);
        chk("t3 lanes", 128'(gl[1].u_if.lanes_out), 128'h00000000_BBBBBBBB_AAAAAAAA);
        chk("t3 done", 128'(gl[1].u_if.group_done), 128'h0);
        chk("t3 ptr", 128'(gl[1].u_if.lane_ptr), 128'h0);

        // Flush together with the completing word counts as a normal group
        step(1'b1, 32'hC0C0C0C0, 1'b0);
        step(1'b1, 32'hD0D0D0D0, 1'b1);
        chk("flush+last done nl2", 128'(gl[0].u_if.group_done), 128'h1);
        chk("flush+last lanes nl2", 128'(gl[0].u_if.lanes_out), 128'hD0D0D0D0_C0C0C0C0);

        // Mode change during FILL is deferred; reset mid-group
        mode_align = 1'b0;
        do_reset();
        step(1'b1, 32'h01010101, 1'b0);
        chk("t5 w1 valid", 128'(gl[1].u_if.valid_out), 128'h1);
        mode_align = 1'b1;
        step(1'b1, 32'h02020202, 1'b0);
        chk("t5 w2 valid", 128'(gl[1].u_if.valid_out), 128'h2);
        step(1'b1, 32'h03030303, 1'b0);
        chk("t5 w3 valid", 128'(gl[1].u_if.valid_out), 128'h4);
        step(1'b1, 32'h04040404, 1'b0);
        chk("t5 align valid", 128'(gl[1].u_if.valid_out), 128'h0);
        step(1'b1, 32'h05050505, 1'b0);
        chk("t5 ptr", 128'(gl[1].u_if.lane_ptr), 128'h2);
        reset = 1'b1;
        step(1'b1, 32'h06060606, 1'b0);
        reset = 1'b0;
        chk("t5 rst valid", 128'(gl[1].u_if.valid_out), 128'h0);
        chk("t5 rst done", 128'(gl[1].u_if.group_done), 128'h0);
        chk("t5 rst lanes", 128'(gl[1].u_if.lanes_out), 128'h0);
        chk("t5 rst ptr", 128'(gl[1].u_if.lane_ptr), 128'h0);

        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
